sub_int32_serial: RTL and testbench

Bit-serial 32-bit two's-complement subtractor (diff = A − B mod 2^32). It is the inverse-operation companion to the parallel ripple-carry int32 adder. It processes one bit per cycle, LSB first, through a single full-subtractor cell and a registered borrow, matching the bit-serial row-wise execution model of our PIM targets. Operands enter and results leave through valid/ready handshakes, so it drops between a row-buffer reader and a result writer.

---
 rtl/sub_int32_serial_if.sv | 36 +++
 rtl/sub_int32_serial.sv | 128 ++++++++++++
 tb/tb_sub_int32_serial.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_int32_serial_if.sv
// Handshake bundle for the bit-serial subtractor: operand channel in, result channel out.
// The ovf signal exists only when SUB_INT32_OVF_EN is defined.
interface sub_int32_serial_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
`ifdef SUB_INT32_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, ovf
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff
    );
`endif
endinterface

// File: rtl/sub_int32_serial.sv
// Bit-serial two's-complement subtractor, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow flag is compiled in with SUB_INT32_OVF_EN.
module sub_int32_serial #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    sub_int32_serial_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic [CW-1:0]    cnt_reg;
    logic             out_valid_reg;

    logic [WIDTH-1:0] a_sh_next;
    logic [WIDTH-1:0] b_sh_next;
    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             borrow_next;

    // Full-subtractor cell on the current LSBs.
    assign a0          = a_sh_reg[0];
    assign b0          = b_sh_reg[0];
    assign d_bit       = a0 ^ b0 ^ borrow_reg;
    assign borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow_reg);

    // Operand shift-right network; zeros enter from the top.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_sh_next[gi] = a_sh_reg[gi+1];
            assign b_sh_next[gi] = b_sh_reg[gi+1];
        end
    endgenerate
    assign a_sh_next[WIDTH-1] = 1'b0;
    assign b_sh_next[WIDTH-1] = 1'b0;

`ifdef SUB_INT32_OVF_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic ovf_reg;
    logic ovf_next;

    // Operands of differing sign whose result sign departs from the minuend overflowed.
    assign ovf_next = (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ d_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && bus.in_valid) begin
                a_msb_reg <= bus.a[WIDTH-1];
                b_msb_reg <= bus.b[WIDTH-1];
            end
            if (state_reg == RUN && cnt_reg == LAST_BIT) begin
                ovf_reg <= ovf_next;
            end
        end
    end

    assign bus.ovf = ovf_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            diff_reg      <= '0;
            borrow_reg    <= 1'b0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh_reg   <= bus.a;
                        b_sh_reg   <= bus.b;
                        borrow_reg <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg   <= a_sh_next;
                    b_sh_reg   <= b_sh_next;
                    diff_reg   <= {d_bit, diff_reg[WIDTH-1:1]};
                    borrow_reg <= borrow_next;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_BIT) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    // Result and flag stay frozen until the consumer takes them.
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.diff      = diff_reg;
endmodule

// File: tb/tb_sub_int32_serial.sv
// Directed self-checking bench for sub_int32_serial; ovf checks engage when SUB_INT32_OVF_EN is defined.
module tb_sub_int32_serial;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sub_int32_serial_if #(.WIDTH(WIDTH)) bus ();

    sub_int32_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic get_ovf();
`ifdef SUB_INT32_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Present one pair, wait (bounded) for out_valid; returns at #1 after the out_valid edge.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input bit scramble,
                         output logic [31:0] d, output logic o, output int lat);
        @(negedge clk);
        bus.a = av;
        bus.b = bv;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (scramble) begin
            bus.a = 32'hFFFF0000;
            bus.b = 32'h0000FFFF;
        end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d = bus.diff;
        o = get_ovf();
        $display("op a=%h b=%h diff=%h ovf=%b latency=%0d", av, bv, d, o, lat);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== 32'h0 || get_ovf() !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b diff=%h ovf=%b required 1 0 00000000 0",
                     bus.in_ready, bus.out_valid, bus.diff, get_ovf());
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic o;
        int lat;
        bus.out_ready = 1'b1;
        do_op(32'd5, 32'd3, 1'b0, d, o, lat);
        checks++;
        if (lat !== 32) begin
            failures++;
            $display("FAIL basic_latency: got %0d required 32", lat);
        end
        checks++;
        if (d !== 32'h00000002) begin
            failures++;
            $display("FAIL basic_diff: got %h required 00000002", d);
        end
`ifdef SUB_INT32_OVF_EN
        checks++;
        if (o !== 1'b0) begin
            failures++;
            $display("FAIL basic_ovf: got %b required 0", o);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_retire: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] va [3] = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] vb [3] = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF};
        logic [31:0] vd [3] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        logic        vo [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] d;
        logic o;
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], 1'b0, d, o, lat);
            checks++;
            if (d !== vd[i] || lat !== 32) begin
                failures++;
                $display("FAIL wrap_%0d: diff=%h latency=%0d required %h 32", i, d, lat, vd[i]);
            end
`ifdef SUB_INT32_OVF_EN
            checks++;
            if (o !== vo[i]) begin
                failures++;
                $display("FAIL wrap_ovf_%0d: got %b required %b", i, o, vo[i]);
            end
`else
            if (vo[i] === 1'bx) $display("unreachable");
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic o;
        int lat;
        bus.out_ready = 1'b0;
        do_op(32'h12345678, 32'h02345678, 1'b0, d, o, lat);
        checks++;
        if (d !== 32'h10000000 || lat !== 32) begin
            failures++;
            $display("FAIL bp_diff: diff=%h latency=%0d required 10000000 32", d, lat);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.diff !== 32'h10000000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || get_ovf() !== o) begin
                failures++;
                $display("FAIL bp_hold_%0d: diff=%h out_valid=%b in_ready=%b required 10000000 1 0",
                         i, bus.diff, bus.out_valid, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_retire: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic o;
        int lat;
        bit seen;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.a = 32'd100;
        bus.b = 32'd1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== 32'h0 || get_ovf() !== 1'b0) begin
            failures++;
            $display("FAIL midreset_values: in_ready=%b out_valid=%b diff=%h ovf=%b required 1 0 00000000 0",
                     bus.in_ready, bus.out_valid, bus.diff, get_ovf());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_no_result: out_valid_seen=%b in_ready=%b required 0 1", seen, bus.in_ready);
        end
        do_op(32'd7, 32'd9, 1'b0, d, o, lat);
        checks++;
        if (d !== 32'hFFFFFFFE || lat !== 32) begin
            failures++;
            $display("FAIL midreset_fresh: diff=%h latency=%0d required FFFFFFFE 32", d, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa [3] = '{32'hDEADBEEF, 32'h00000010, 32'hFFFFFFFF};
        logic [31:0] pb [3] = '{32'h12345678, 32'h00000020, 32'hFFFFFFFF};
        logic [31:0] pd [3] = '{32'hCC796877, 32'hFFFFFFF0, 32'h00000000};
        logic [31:0] res [3];
        int acc_cyc [3];
        int k = 0;
        int n = 0;
        int extra = 0;
        int cyc = 0;
        bit acc;
        bus.out_ready = 1'b1;
        bus.a = pa[0];
        bus.b = pb[0];
        bus.in_valid = 1'b1;
        while (n < 3 && cyc < 300) begin
            @(negedge clk);
            acc = bus.in_ready && bus.in_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (acc && k < 3) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < 3) begin
                    bus.a = pa[k];
                    bus.b = pb[k];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid === 1'b1) begin
                if (n < 3) res[n] = bus.diff;
                $display("b2b result %0d diff=%h", n, bus.diff);
                n++;
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) extra++;
        end
        checks++;
        if (n !== 3 || extra !== 0 || k !== 3) begin
            failures++;
            $display("FAIL b2b_count: results=%0d extra=%0d accepts=%0d required 3 0 3", n, extra, k);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= n || res[i] !== pd[i]) begin
                failures++;
                $display("FAIL b2b_diff_%0d: got %h required %h", i, (i < n) ? res[i] : 32'hx, pd[i]);
            end
        end
        // WIDTH RUN edges, one DONE->IDLE edge, then the next accept edge.
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (k < 3 || acc_cyc[i+1] - acc_cyc[i] !== WIDTH + 2) begin
                failures++;
                $display("FAIL b2b_spacing_%0d: got %0d required %0d", i,
                         (k < 3) ? -1 : acc_cyc[i+1] - acc_cyc[i], WIDTH + 2);
            end
        end
    endtask

    task automatic test_input_stability();
        logic [31:0] d;
        logic o;
        int lat;
        bus.out_ready = 1'b1;
        do_op(32'h00001000, 32'h00000001, 1'b1, d, o, lat);
        checks++;
        if (d !== 32'h00000FFF || lat !== 32) begin
            failures++;
            $display("FAIL stability_diff: diff=%h latency=%0d required 00000FFF 32", d, lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_input_stability();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
